axilite_mmio_guard: RTL and testbench

- AXI-Lite timeout guard on the MMIO path from pardcore M_AXILITE_MMIO to zynq_soc S_AXILITE_MMIO, in the uncore clock domain.
- Forwards one outstanding write and one outstanding read. Each direction is independent.
- If the PS side does not complete a transaction within TIMEOUT_CYCLES, the guard returns SLVERR to the core so the core cannot hang.
- After a timeout, any late PS response is drained and discarded.

---
 rtl/axilite_mmio_guard_if.sv | 50 +++++
 rtl/axilite_mmio_guard.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axilite_mmio_guard.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_mmio_guard_if.sv
// AXI-Lite link bundle shared by the core-facing and PS-facing sides.
// master drives requests; slave drives readies and responses.
interface axilite_mmio_guard_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axilite_mmio_guard.sv
// AXI-Lite MMIO timeout guard: one write and one read in flight,
// SLVERR to the core on PS stall, late PS responses drained.
module axilite_mmio_guard #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        uncoreclk,
  input  logic        uncore_rstn,
  axilite_mmio_guard_if.slave  s_axilite,
  axilite_mmio_guard_if.master m_axilite,
  output logic        timeout_pulse,
  output logic [7:0]  timeout_count
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_RESP, ST_ERR, ST_DRAIN
  } st_e;

  st_e w_st_q, w_st_d;
  st_e r_st_q, r_st_d;

  logic                  aw_cap_q, aw_cap_d;
  logic                  w_cap_q, w_cap_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  b_got_q, b_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [15:0]           wtmr_q, wtmr_d;

  logic                  ar_done_q, ar_done_d;
  logic                  r_got_q, r_got_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [15:0]           rtmr_q, rtmr_d;

  logic [7:0]            cnt_q, cnt_d;

  logic s_awready_c, s_wready_c, s_bvalid_c;
  logic m_awvalid_c, m_wvalid_c, m_bready_c;
  logic s_arready_c, s_rvalid_c;
  logic m_arvalid_c, m_rready_c;
  logic w_to, r_to;

  logic s_aw_hs, s_w_hs, m_aw_hs, m_w_hs;
  logic aw_fin, w_fin, b_fin;
  logic s_ar_hs, m_ar_hs, ar_fin, r_fin;
  logic [8:0] cnt_sum;

  // Write FSM next state, captures and master-side progress
  always_comb begin
    w_st_d      = w_st_q;
    aw_cap_d    = aw_cap_q;
    w_cap_d     = w_cap_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    b_got_d     = b_got_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    wtmr_d      = wtmr_q;
    s_awready_c = 1'b0;
    s_wready_c  = 1'b0;
    s_bvalid_c  = 1'b0;
    m_awvalid_c = 1'b0;
    m_wvalid_c  = 1'b0;
    m_bready_c  = 1'b0;
    w_to        = 1'b0;
    if (w_st_q == ST_REQ || w_st_q == ST_ERR
        || w_st_q == ST_DRAIN) begin
      m_awvalid_c = !aw_done_q;
      m_wvalid_c  = !w_done_q;
      m_bready_c  = 1'b1;
    end
    if (w_st_q == ST_IDLE) begin
      s_awready_c = !aw_cap_q;
      s_wready_c  = !w_cap_q;
    end
    s_aw_hs = s_axilite.awvalid && s_awready_c;
    s_w_hs  = s_axilite.wvalid && s_wready_c;
    m_aw_hs = m_awvalid_c && m_axilite.awready;
    m_w_hs  = m_wvalid_c && m_axilite.wready;
    aw_fin  = aw_done_q || m_aw_hs;
    w_fin   = w_done_q || m_w_hs;
    b_fin   = b_got_q || m_axilite.bvalid;
    if (m_aw_hs) aw_done_d = 1'b1;
    if (m_w_hs)  w_done_d  = 1'b1;
    unique case (w_st_q)
      ST_IDLE: begin
        if (s_aw_hs) begin
          aw_cap_d = 1'b1;
          awaddr_d = s_axilite.awaddr;
        end
        if (s_w_hs) begin
          w_cap_d = 1'b1;
          wdata_d = s_axilite.wdata;
          wstrb_d = s_axilite.wstrb;
        end
        if ((aw_cap_q || s_aw_hs)
            && (w_cap_q || s_w_hs)) begin
          w_st_d    = ST_REQ;
          wtmr_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          b_got_d   = 1'b0;
        end
      end
      ST_REQ: begin
        wtmr_d = wtmr_q + 16'd1;
        if (m_axilite.bvalid) begin
          bresp_d = m_axilite.bresp;
          w_st_d  = ST_RESP;
        end else if (wtmr_q == TMAX) begin
          w_to    = 1'b1;
          bresp_d = 2'b10;
          w_st_d  = ST_ERR;
        end
      end
      ST_RESP: begin
        s_bvalid_c = 1'b1;
        if (s_axilite.bready) begin
          w_st_d   = ST_IDLE;
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
        end
      end
      ST_ERR: begin
        s_bvalid_c = 1'b1;
        if (m_axilite.bvalid) b_got_d = 1'b1;
        if (s_axilite.bready) begin
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
          if (aw_fin && w_fin && b_fin)
            w_st_d = ST_IDLE;
          else
            w_st_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_axilite.bvalid) b_got_d = 1'b1;
        if (aw_fin && w_fin && b_fin)
          w_st_d = ST_IDLE;
      end
      default: w_st_d = ST_IDLE;
    endcase
  end

  // Read FSM next state, capture and master-side progress
  always_comb begin
    r_st_d      = r_st_q;
    ar_done_d   = ar_done_q;
    r_got_d     = r_got_q;
    araddr_d    = araddr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rtmr_d      = rtmr_q;
    s_arready_c = 1'b0;
    s_rvalid_c  = 1'b0;
    m_arvalid_c = 1'b0;
    m_rready_c  = 1'b0;
    r_to        = 1'b0;
    if (r_st_q == ST_REQ || r_st_q == ST_ERR
        || r_st_q == ST_DRAIN) begin
      m_arvalid_c = !ar_done_q;
      m_rready_c  = 1'b1;
    end
    s_arready_c = (r_st_q == ST_IDLE);
    s_ar_hs = s_axilite.arvalid && s_arready_c;
    m_ar_hs = m_arvalid_c && m_axilite.arready;
    ar_fin  = ar_done_q || m_ar_hs;
    r_fin   = r_got_q || m_axilite.rvalid;
    if (m_ar_hs) ar_done_d = 1'b1;
    unique case (r_st_q)
      ST_IDLE: begin
        if (s_ar_hs) begin
          araddr_d  = s_axilite.araddr;
          r_st_d    = ST_REQ;
          rtmr_d    = '0;
          ar_done_d = 1'b0;
          r_got_d   = 1'b0;
        end
      end
      ST_REQ: begin
        rtmr_d = rtmr_q + 16'd1;
        if (m_axilite.rvalid) begin
          rdata_d = m_axilite.rdata;
          rresp_d = m_axilite.rresp;
          r_st_d  = ST_RESP;
        end else if (rtmr_q == TMAX) begin
          r_to    = 1'b1;
          rdata_d = ERR_RDATA;
          rresp_d = 2'b10;
          r_st_d  = ST_ERR;
        end
      end
      ST_RESP: begin
        s_rvalid_c = 1'b1;
        if (s_axilite.rready) r_st_d = ST_IDLE;
      end
      ST_ERR: begin
        s_rvalid_c = 1'b1;
        if (m_axilite.rvalid) r_got_d = 1'b1;
        if (s_axilite.rready) begin
          if (ar_fin && r_fin)
            r_st_d = ST_IDLE;
          else
            r_st_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_axilite.rvalid) r_got_d = 1'b1;
        if (ar_fin && r_fin) r_st_d = ST_IDLE;
      end
      default: r_st_d = ST_IDLE;
    endcase
  end

  // Saturating timeout counter; simultaneous timeouts count twice
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {8'd0, w_to}
            + {8'd0, r_to};
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // State and payload registers
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      w_st_q    <= ST_IDLE;
      r_st_q    <= ST_IDLE;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      wtmr_q    <= '0;
      ar_done_q <= 1'b0;
      r_got_q   <= 1'b0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rtmr_q    <= '0;
      cnt_q     <= 8'd0;
    end else begin
      w_st_q    <= w_st_d;
      r_st_q    <= r_st_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      b_got_q   <= b_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      wtmr_q    <= wtmr_d;
      ar_done_q <= ar_done_d;
      r_got_q   <= r_got_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rtmr_q    <= rtmr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_axilite.awready = s_awready_c;
  assign s_axilite.wready  = s_wready_c;
  assign s_axilite.bvalid  = s_bvalid_c;
  assign s_axilite.bresp   = bresp_q;
  assign s_axilite.arready = s_arready_c;
  assign s_axilite.rvalid  = s_rvalid_c;
  assign s_axilite.rdata   = rdata_q;
  assign s_axilite.rresp   = rresp_q;

  assign m_axilite.awaddr  = awaddr_q;
  assign m_axilite.awvalid = m_awvalid_c;
  assign m_axilite.wdata   = wdata_q;
  assign m_axilite.wstrb   = wstrb_q;
  assign m_axilite.wvalid  = m_wvalid_c;
  assign m_axilite.bready  = m_bready_c;
  assign m_axilite.araddr  = araddr_q;
  assign m_axilite.arvalid = m_arvalid_c;
  assign m_axilite.rready  = m_rready_c;

  assign timeout_pulse = w_to || r_to;
  assign timeout_count = cnt_q;

endmodule

// File: tb/tb_axilite_mmio_guard.sv
// Directed bench for axilite_mmio_guard with a 16-cycle timeout.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_axilite_mmio_guard;

  logic       clk;
  logic       rst_n;
  logic       pulse;
  logic [7:0] tcnt;

  int n_chk;
  int n_fail;
  int n_aw;
  int n_w;
  int n_pulse;

  axilite_mmio_guard_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
  axilite_mmio_guard_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axilite_mmio_guard #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .uncoreclk    (clk),
    .uncore_rstn  (rst_n),
    .s_axilite    (s_if),
    .m_axilite    (m_if),
    .timeout_pulse(pulse),
    .timeout_count(tcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_if.awvalid && m_if.awready) n_aw++;
    if (m_if.wvalid && m_if.wready) n_w++;
    if (pulse) n_pulse++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // n quiet cycles: no pulse and no slave response expected
  task automatic quiet(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      mid();
      if (pulse || s_if.bvalid || s_if.rvalid) bad++;
    end
    check(tag, bad, 0);
  endtask

  // One read that times out with AR accepted at once, late R drained
  task automatic read_timeout();
    int k;
    cyc();
    s_if.arvalid = 1'b1;
    s_if.araddr  = 32'h6000_0100;
    cyc();
    s_if.arvalid = 1'b0;
    m_if.arready = 1'b1;
    cyc();
    m_if.arready = 1'b0;
    k = 0;
    while (!s_if.rvalid && k < 40) begin
      cyc();
      k++;
    end
    if (k >= 40) check("sat_rvalid_wait", 0, 1);
    s_if.rready = 1'b1;
    cyc();
    s_if.rready = 1'b0;
    m_if.rvalid = 1'b1;
    cyc();
    m_if.rvalid = 1'b0;
  endtask

  initial begin
    int aw0, w0, p0;
    n_chk = 0; n_fail = 0;
    n_aw = 0; n_w = 0; n_pulse = 0;
    rst_n = 1'b0;
    s_if.awaddr = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0;
    s_if.wvalid = 1'b0; s_if.bready = 1'b0;
    s_if.araddr = '0; s_if.arvalid = 1'b0;
    s_if.rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0;
    m_if.rdata = '0; m_if.rresp = 2'b00;

    repeat (3) cyc();
    mid();
    check("rst_awready", s_if.awready, 1);
    check("rst_wready", s_if.wready, 1);
    check("rst_arready", s_if.arready, 1);
    check("rst_bvalid", s_if.bvalid, 0);
    check("rst_rvalid", s_if.rvalid, 0);
    check("rst_m_valids",
          {m_if.awvalid, m_if.wvalid, m_if.arvalid}, 0);
    check("rst_m_readies", {m_if.bready, m_if.rready}, 0);
    check("rst_pulse", pulse, 0);
    check("rst_count", tcnt, 0);
    rst_n = 1'b1;

    // Normal write, B three cycles after the handshake
    cyc();
    s_if.awvalid = 1'b1; s_if.awaddr = 32'h6000_0000;
    s_if.wvalid = 1'b1; s_if.wdata = 32'h1234_5678;
    s_if.wstrb = 4'hF;
    mid();
    check("w1_s_ready", {s_if.awready, s_if.wready}, 2'b11);
    cyc();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    mid();
    check("w1_m_valids", {m_if.awvalid, m_if.wvalid}, 2'b11);
    check("w1_awaddr", m_if.awaddr, 32'h6000_0000);
    check("w1_wdata", m_if.wdata, 32'h1234_5678);
    check("w1_wstrb", m_if.wstrb, 4'hF);
    check("w1_bready", m_if.bready, 1);
    cyc();
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    mid();
    check("w1_valids_drop", {m_if.awvalid, m_if.wvalid}, 0);
    cyc();
    cyc();
    m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
    mid();
    check("w1_no_early_b", s_if.bvalid, 0);
    cyc();
    m_if.bvalid = 1'b0;
    s_if.bready = 1'b1;
    mid();
    check("w1_bvalid", s_if.bvalid, 1);
    check("w1_bresp", s_if.bresp, 2'b00);
    cyc();
    s_if.bready = 1'b0;
    mid();
    check("w1_b_done", s_if.bvalid, 0);
    check("w1_idle", s_if.awready, 1);
    check("w1_count", tcnt, 0);

    // W presented two cycles before AW
    aw0 = n_aw; w0 = n_w;
    cyc();
    s_if.wvalid = 1'b1; s_if.wdata = 32'hCAFE_0001;
    s_if.wstrb = 4'h3;
    mid();
    check("w2_wready", s_if.wready, 1);
    cyc();
    s_if.wvalid = 1'b0;
    mid();
    check("w2_wready_off", s_if.wready, 0);
    check("w2_no_issue", m_if.wvalid, 0);
    cyc();
    s_if.awvalid = 1'b1; s_if.awaddr = 32'h6000_0040;
    mid();
    check("w2_awready", s_if.awready, 1);
    cyc();
    s_if.awvalid = 1'b0;
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    mid();
    check("w2_m_valids", {m_if.awvalid, m_if.wvalid}, 2'b11);
    check("w2_awaddr", m_if.awaddr, 32'h6000_0040);
    check("w2_wdata", m_if.wdata, 32'hCAFE_0001);
    cyc();
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.bvalid = 1'b1; m_if.bresp = 2'b01;
    cyc();
    m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
    s_if.bready = 1'b1;
    mid();
    check("w2_bresp", {s_if.bvalid, s_if.bresp}, 3'b101);
    cyc();
    s_if.bready = 1'b0;
    mid();
    check("w2_single_aw", n_aw - aw0, 1);
    check("w2_single_w", n_w - w0, 1);

    // Write timeout, late B drained
    cyc();
    s_if.awvalid = 1'b1; s_if.awaddr = 32'h6000_0080;
    s_if.wvalid = 1'b1; s_if.wdata = 32'h0BAD_F00D;
    cyc();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    mid();
    check("w3_req_pulse", pulse, 0);
    cyc();
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    mid();
    quiet(13, "w3_quiet");
    cyc();
    mid();
    check("w3_pulse", pulse, 1);
    check("w3_no_b_yet", s_if.bvalid, 0);
    cyc();
    s_if.bready = 1'b1;
    mid();
    check("w3_err_bvalid", s_if.bvalid, 1);
    check("w3_err_bresp", s_if.bresp, 2'b10);
    check("w3_pulse_off", pulse, 0);
    check("w3_count", tcnt, 1);
    cyc();
    s_if.bready = 1'b0;
    mid();
    check("w3_drain_awready", s_if.awready, 0);
    check("w3_drain_bvalid", s_if.bvalid, 0);
    cyc();
    m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
    mid();
    check("w3_late_b_hidden", s_if.bvalid, 0);
    cyc();
    m_if.bvalid = 1'b0;
    mid();
    check("w3_back_idle", s_if.awready, 1);

    // Read timeout with AR stalled 20 cycles
    cyc();
    s_if.arvalid = 1'b1; s_if.araddr = 32'h6000_0010;
    mid();
    check("r4_arready", s_if.arready, 1);
    cyc();
    s_if.arvalid = 1'b0;
    mid();
    check("r4_arvalid", m_if.arvalid, 1);
    check("r4_araddr", m_if.araddr, 32'h6000_0010);
    quiet(14, "r4_quiet");
    cyc();
    mid();
    check("r4_pulse", pulse, 1);
    cyc();
    s_if.rready = 1'b1;
    mid();
    check("r4_err_rvalid", s_if.rvalid, 1);
    check("r4_err_rresp", s_if.rresp, 2'b10);
    check("r4_err_rdata", s_if.rdata, 32'hDEADBEEF);
    check("r4_arvalid_held", m_if.arvalid, 1);
    check("r4_count", tcnt, 2);
    cyc();
    s_if.rready = 1'b0;
    mid();
    check("r4_drain_arvalid", m_if.arvalid, 1);
    check("r4_drain_arready", s_if.arready, 0);
    check("r4_drain_rvalid", s_if.rvalid, 0);
    cyc();
    cyc();
    cyc();
    m_if.arready = 1'b1;
    mid();
    check("r4_arvalid_late", m_if.arvalid, 1);
    cyc();
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'h0000_AAAA;
    mid();
    check("r4_arvalid_off", m_if.arvalid, 0);
    check("r4_late_r_hidden", s_if.rvalid, 0);
    cyc();
    m_if.rvalid = 1'b0;
    mid();
    check("r4_back_idle", s_if.arready, 1);
    check("r4_still_hidden", s_if.rvalid, 0);
    cyc();
    s_if.arvalid = 1'b1; s_if.araddr = 32'h6000_0014;
    cyc();
    s_if.arvalid = 1'b0;
    m_if.arready = 1'b1;
    mid();
    check("r4n_araddr", m_if.araddr, 32'h6000_0014);
    cyc();
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'h1357_9BDF;
    cyc();
    m_if.rvalid = 1'b0; m_if.rdata = '0;
    s_if.rready = 1'b1;
    mid();
    check("r4n_rvalid", s_if.rvalid, 1);
    check("r4n_rdata", s_if.rdata, 32'h1357_9BDF);
    check("r4n_rresp", s_if.rresp, 2'b00);
    cyc();
    s_if.rready = 1'b0;

    // B arrives exactly on the timeout cycle
    cyc();
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
    s_if.awaddr = 32'h6000_00C0;
    cyc();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    cyc();
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    mid();
    quiet(13, "w5_quiet");
    cyc();
    m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
    mid();
    check("w5_no_pulse", pulse, 0);
    cyc();
    m_if.bvalid = 1'b0;
    s_if.bready = 1'b1;
    mid();
    check("w5_okay", {s_if.bvalid, s_if.bresp}, 3'b100);
    check("w5_count", tcnt, 2);
    cyc();
    s_if.bready = 1'b0;

    // Write and read time out in the same cycle
    p0 = n_pulse;
    cyc();
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
    s_if.arvalid = 1'b1; s_if.araddr = 32'h6000_0020;
    cyc();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    s_if.arvalid = 1'b0;
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    m_if.arready = 1'b1;
    cyc();
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.arready = 1'b0;
    mid();
    quiet(13, "c6_quiet");
    cyc();
    mid();
    check("c6_pulse", pulse, 1);
    cyc();
    s_if.bready = 1'b1; s_if.rready = 1'b1;
    mid();
    check("c6_bresp", {s_if.bvalid, s_if.bresp}, 3'b110);
    check("c6_rresp", {s_if.rvalid, s_if.rresp}, 3'b110);
    check("c6_rdata", s_if.rdata, 32'hDEADBEEF);
    check("c6_count", tcnt, 4);
    check("c6_one_pulse", n_pulse - p0, 1);
    cyc();
    s_if.bready = 1'b0; s_if.rready = 1'b0;
    m_if.bvalid = 1'b1; m_if.rvalid = 1'b1;
    mid();
    check("c6_drained", {s_if.bvalid, s_if.rvalid}, 0);
    cyc();
    m_if.bvalid = 1'b0; m_if.rvalid = 1'b0;
    mid();
    check("c6_idle", {s_if.awready, s_if.arready}, 2'b11);

    // Saturation: 252 more timeouts, count pinned at FF
    for (int i = 0; i < 251; i++) read_timeout();
    mid();
    check("sat_at_ff", tcnt, 8'hFF);
    p0 = n_pulse;
    read_timeout();
    mid();
    check("sat_hold", tcnt, 8'hFF);
    check("sat_pulse", n_pulse - p0, 1);

    // Reset in the middle of a write
    cyc();
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
    cyc();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    #1;
    rst_n = 1'b0;
    mid();
    check("mrst_awvalid", m_if.awvalid, 0);
    check("mrst_count", tcnt, 0);
    check("mrst_awready", s_if.awready, 1);
    cyc();
    rst_n = 1'b1;
    cyc();
    mid();
    check("mrst_stay_idle", m_if.awvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
